rst_cipher_ctrl: RTL

Sequencer for the RST substitution/rotation cipher core. It collects a 12-character key byte-serially, installs it in the core through a core reset and key-apply sequence, and checks the core's key error flag. It then streams plaintext bytes into the core one character at a time and buffers each 2-character ciphertext onto a valid/ready output. It sits between the host byte interfaces and the cipher core, and owns the core's reset, key bus and `ptxt_valid` strobe.

---
 rtl/rst_cipher_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rst_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// rst_cipher_ctrl
//
// Sequencer for the RST substitution/rotation cipher core. It gathers a
// 12-character key byte-serially, installs it in the core with a core reset
// and a key-apply sequence, and checks the core's key error flag. Once a key
// is installed it feeds plaintext bytes to the core one at a time and buffers
// each 2-character ciphertext onto a valid/ready output.
//
// Handshakes: every stream uses plain valid/ready. A byte moves only on a
// rising edge where valid && ready are both high. The producer holds its data
// stable while valid is high and ready is low. Ready never depends on valid.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rekey                 one-cycle pulse: drop everything, collect a new key
//   key_byte/valid/ready  key character stream (first char -> core_key[95:88])
//   ptxt_byte/in_valid/in_ready   plaintext stream
//   ctxt_out/valid/ready  ciphertext stream, [15:8] row char, [7:0] col char
//   key_installed         level, the core holds a valid table
//   err_key               level, the last key check failed
//   err_ptxt              one-cycle pulse, the core rejected a plaintext char
//   char_count            ciphertexts produced since the last key install
//   core_*                cipher core reset, key bus, plaintext strobe, results
//   state_dbg             current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module rst_cipher_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rekey,
  input  logic [7:0]       key_byte,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [7:0]       ptxt_byte,
  input  logic             ptxt_in_valid,
  output logic             ptxt_in_ready,
  output logic [15:0]      ctxt_out,
  output logic             ctxt_out_valid,
  input  logic             ctxt_out_ready,
  output logic             key_installed,
  output logic             err_key,
  output logic             err_ptxt,
  output logic [CNT_W-1:0] char_count,
  output logic             core_rst_n,
  output logic [95:0]      core_key,
  output logic [7:0]       core_ptxt,
  output logic             core_ptxt_valid,
  input  logic [15:0]      core_ctxt,
  input  logic             core_ctxt_ready,
  input  logic             core_err_invalid_key,
  input  logic             core_err_invalid_ptxt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    KEY_COLLECT = 3'd0,
    CORE_RST    = 3'd1,
    KEY_APPLY   = 3'd2,
    KEY_SETTLE  = 3'd3,
    KEY_CHECK   = 3'd4,
    READY       = 3'd5,
    ISSUE       = 3'd6,
    RESP        = 3'd7
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        active;     // low until the first clock after reset release
  logic [3:0]  byte_cnt;
  logic [95:0] key_asm;
  logic        key_take;
  logic        ptxt_take;

  assign state_dbg = state;
  assign key_take  = key_valid && key_ready;
  assign ptxt_take = ptxt_in_valid && ptxt_in_ready;

  // Next state and combinational handshake outputs.
  always_comb begin
    state_next      = state;
    key_ready       = 1'b0;
    ptxt_in_ready   = 1'b0;
    core_ptxt_valid = 1'b0;
    case (state)
      KEY_COLLECT: begin
        key_ready = active && !rekey;
        if (key_valid && active && !rekey && (byte_cnt == 4'd11)) begin
          state_next = CORE_RST;
        end
      end
      CORE_RST:   state_next = KEY_APPLY;
      KEY_APPLY:  state_next = KEY_SETTLE;
      KEY_SETTLE: state_next = KEY_CHECK;
      KEY_CHECK: begin
        state_next = core_err_invalid_key ? KEY_COLLECT : READY;
      end
      READY: begin
        // A new char may enter only if its ciphertext will find room.
        ptxt_in_ready = !rekey && (!ctxt_out_valid || ctxt_out_ready);
        if (ptxt_in_valid && !rekey && (!ctxt_out_valid || ctxt_out_ready)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // The core rotates its table once per strobe: exactly one cycle.
        core_ptxt_valid = 1'b1;
        state_next      = RESP;
      end
      RESP:    state_next = READY;
      default: state_next = KEY_COLLECT;
    endcase
    if (rekey) begin
      state_next = KEY_COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= KEY_COLLECT;
      active         <= 1'b0;
      byte_cnt       <= 4'd0;
      key_asm        <= 96'h0;
      core_key       <= 96'h0;
      core_rst_n     <= 1'b0;
      core_ptxt      <= 8'h0;
      ctxt_out       <= 16'h0;
      ctxt_out_valid <= 1'b0;
      key_installed  <= 1'b0;
      err_key        <= 1'b0;
      err_ptxt       <= 1'b0;
      char_count     <= '0;
    end else begin
      state      <= state_next;
      active     <= 1'b1;
      core_rst_n <= (state_next != CORE_RST);
      err_ptxt   <= 1'b0;

      // Zeroing the bus in CORE_RST guarantees the core sees a key change
      // even when the same key is installed twice in a row.
      if (state_next == CORE_RST) begin
        core_key <= 96'h0;
      end else if (state_next == KEY_APPLY) begin
        core_key <= key_asm;
      end

      if (ctxt_out_ready) begin
        ctxt_out_valid <= 1'b0;
      end

      if (rekey) begin
        byte_cnt       <= 4'd0;
        ctxt_out_valid <= 1'b0;
        key_installed  <= 1'b0;
        err_key        <= 1'b0;
        char_count     <= '0;
      end else begin
        case (state)
          KEY_COLLECT: begin
            if (key_take) begin
              key_asm  <= {key_asm[87:0], key_byte};
              byte_cnt <= (byte_cnt == 4'd11) ? 4'd0 : byte_cnt + 4'd1;
            end
          end
          KEY_CHECK: begin
            if (core_err_invalid_key) begin
              err_key       <= 1'b1;
              key_installed <= 1'b0;
            end else begin
              err_key       <= 1'b0;
              key_installed <= 1'b1;
              char_count    <= '0;
            end
          end
          READY: begin
            if (ptxt_take) begin
              core_ptxt <= ptxt_byte;
            end
          end
          RESP: begin
            // The buffer is empty or draining here, so a reload never
            // overwrites an undelivered ciphertext.
            if (core_ctxt_ready) begin
              ctxt_out       <= core_ctxt;
              ctxt_out_valid <= 1'b1;
              char_count     <= char_count + 1'b1;
            end else if (core_err_invalid_ptxt) begin
              err_ptxt <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
